// File: rtl/instr_encoder_if.sv
// Request and encoded-instruction handshakes for instr_encoder.
// master = request producer and instruction consumer; slave = the encoder.
interface instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [31:0] req_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        err;

    modport master (
        output req_valid, req_op, req_rd, req_rs, req_rt, req_imm, instr_ready,
        input  req_ready, instr_valid, instr, err
    );

    modport slave (
        input  req_valid, req_op, req_rd, req_rs, req_rt, req_imm, instr_ready,
        output req_ready, instr_valid, instr, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Streaming MIPS encoder: symbolic request -> 32-bit word through one registered stage (1-cycle latency).
// req_ready follows output-stage backpressure; `li` 3-word expansion exists only when LI_EXPAND_EN is defined.
module instr_encoder (
    input  logic           clk,
    input  logic           reset,
    instr_encoder_if.slave bus
);
    localparam logic [5:0] OPC_ORI = 6'b001101;

    function automatic logic [31:0] f_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [4:0] sh,
                                            input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] f_itype(input logic [5:0] opc, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    logic        r_instr_valid;
    logic [31:0] r_instr;
    logic        r_err;
    logic        w_load;
    logic        w_accept;
    logic        w_legal;
    logic [31:0] w_word;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [31:0] w_imm;

`ifdef LI_EXPAND_EN
    typedef enum logic [1:0] {S_IDLE, S_LI_SHIFT, S_LI_LOW} state_t;
    state_t      r_state;
    logic [4:0]  r_li_rt;
    logic [15:0] r_li_imm;
    logic        w_li_long;
`else
    logic        w_unused_imm;
    assign w_unused_imm = ^w_imm[31:26];
`endif

    assign w_rs  = bus.req_rs;
    assign w_rt  = bus.req_rt;
    assign w_rd  = bus.req_rd;
    assign w_imm = bus.req_imm;

    // Output stage can take a new word when empty or when its current word leaves this cycle.
    assign w_load = !r_instr_valid || bus.instr_ready;
`ifdef LI_EXPAND_EN
    assign bus.req_ready = (r_state == S_IDLE) && w_load;
`else
    assign bus.req_ready = w_load;
`endif
    assign w_accept        = bus.req_valid && bus.req_ready;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.err         = r_err;

    always_comb begin
        w_word  = 32'h0;
        w_legal = 1'b1;
`ifdef LI_EXPAND_EN
        w_li_long = 1'b0;
`endif
        case (bus.req_op)
            5'd0:  w_word = f_rtype(w_rs, w_rt, w_rd, 5'd0, 6'b100000);
            5'd1:  w_word = f_rtype(w_rs, w_rt, w_rd, 5'd0, 6'b100010);
            5'd2:  w_word = f_rtype(w_rs, w_rt, w_rd, 5'd0, 6'b100100);
            5'd3:  w_word = f_rtype(w_rs, w_rt, w_rd, 5'd0, 6'b100101);
            5'd4:  w_word = f_rtype(w_rs, w_rt, w_rd, 5'd0, 6'b100110);
            5'd5:  w_word = f_rtype(w_rs, w_rt, w_rd, 5'd0, 6'b100111);
            5'd6:  w_word = f_rtype(w_rs, w_rt, w_rd, 5'd0, 6'b101010);
            5'd7:  w_word = f_rtype(5'd0, w_rt, w_rd, w_imm[4:0], 6'b000000);
            5'd8:  w_word = f_rtype(5'd0, w_rt, w_rd, w_imm[4:0], 6'b000010);
            5'd9:  w_word = f_rtype(5'd0, w_rt, w_rd, w_imm[4:0], 6'b000011);
            5'd10: w_word = f_rtype(w_rs, 5'd0, 5'd0, 5'd0, 6'b001001);
            5'd11: w_word = f_itype(6'b001000, w_rs, w_rt, w_imm[15:0]);
            5'd12: w_word = f_itype(6'b001100, w_rs, w_rt, w_imm[15:0]);
            5'd13: w_word = f_itype(OPC_ORI,   w_rs, w_rt, w_imm[15:0]);
            5'd14: w_word = f_itype(6'b001110, w_rs, w_rt, w_imm[15:0]);
            5'd15: w_word = f_itype(6'b100011, w_rs, w_rt, w_imm[15:0]);
            5'd16: w_word = f_itype(6'b101011, w_rs, w_rt, w_imm[15:0]);
            5'd17: w_word = {6'b000010, w_imm[25:0]};
            5'd18: w_word = {6'b000011, w_imm[25:0]};
            5'd19: w_word = f_itype(6'b000100, w_rs, w_rt, w_imm[15:0]);
            5'd20: w_word = f_itype(6'b000101, w_rs, w_rt, w_imm[15:0]);
`ifdef LI_EXPAND_EN
            // li: a short value is a single ori; a long one starts with the upper half.
            5'd21: begin
                w_li_long = |w_imm[31:16];
                w_word    = f_itype(OPC_ORI, 5'd0, w_rt,
                                    w_li_long ? w_imm[31:16] : w_imm[15:0]);
            end
`endif
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_valid <= 1'b0;
            r_instr       <= 32'h0;
            r_err         <= 1'b0;
`ifdef LI_EXPAND_EN
            r_state       <= S_IDLE;
            r_li_rt       <= 5'd0;
            r_li_imm      <= 16'h0;
`endif
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_load) begin
`ifdef LI_EXPAND_EN
                case (r_state)
                    S_IDLE: begin
                        r_instr_valid <= w_accept && w_legal;
                        if (w_accept && w_legal) begin
                            r_instr <= w_word;
                        end
                        if (w_accept && w_li_long) begin
                            r_li_rt  <= w_rt;
                            r_li_imm <= w_imm[15:0];
                            r_state  <= S_LI_SHIFT;
                        end
                    end
                    S_LI_SHIFT: begin
                        r_instr_valid <= 1'b1;
                        r_instr       <= f_rtype(5'd0, r_li_rt, r_li_rt, 5'd16, 6'b000000);
                        r_state       <= S_LI_LOW;
                    end
                    S_LI_LOW: begin
                        r_instr_valid <= 1'b1;
                        r_instr       <= f_itype(OPC_ORI, r_li_rt, r_li_rt, r_li_imm);
                        r_state       <= S_IDLE;
                    end
                    default: begin
                        r_instr_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                endcase
`else
                r_instr_valid <= w_accept && w_legal;
                if (w_accept && w_legal) begin
                    r_instr <= w_word;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized + directed scoreboard bench for instr_encoder; reference model builds words from field tables.
module tb_instr_encoder;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    instr_encoder_if bus ();
    instr_encoder dut (.clk(clk), .reset(reset), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q[$];
    int          err_q[$];

    logic [5:0] rfn [0:10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h09};
    logic [5:0] iop [0:9]  = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h02, 6'h03, 6'h04, 6'h05};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] m_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    // Reference: what a program loader expects for one accepted request.
    task automatic model(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [31:0] imm, input int ecyc);
        int k;
        k = int'(op);
        if (k <= 6)                       exp_q.push_back(m_r(rs, rt, rd, 5'd0, rfn[k]));
        else if (k <= 9)                  exp_q.push_back(m_r(5'd0, rt, rd, imm[4:0], rfn[k]));
        else if (k == 10)                 exp_q.push_back(m_r(rs, 5'd0, 5'd0, 5'd0, rfn[k]));
        else if (k == 17 || k == 18)      exp_q.push_back({iop[k-11], imm[25:0]});
        else if (k >= 11 && k <= 20)      exp_q.push_back(m_i(iop[k-11], rs, rt, imm[15:0]));
`ifdef LI_EXPAND_EN
        else if (k == 21) begin
            if (imm[31:16] == 16'h0) exp_q.push_back(m_i(6'h0D, 5'd0, rt, imm[15:0]));
            else begin
                exp_q.push_back(m_i(6'h0D, 5'd0, rt, imm[31:16]));
                exp_q.push_back(m_r(5'd0, rt, rt, 5'd16, 6'h00));
                exp_q.push_back(m_i(6'h0D, rt, rt, imm[15:0]));
            end
        end
`endif
        else err_q.push_back(ecyc);
    endtask

    // Called just after a rising edge; returns just after the edge that took the request.
    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [31:0] imm);
        bit done = 0;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_rd = rd; bus.req_rs = rs;
        bus.req_rt = rt; bus.req_imm = imm;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                model(op, rd, rs, rt, imm, cyc + 1);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL send_timeout: request op %0d not accepted within 50 cycles", op);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: pops the scoreboard on every output handshake, checks err timing and stall stability.
    initial begin
        bit          prev_stall = 0;
        logic [31:0] prev_instr = 32'h0;
        logic [31:0] exp_w;
        bit          exp_err;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 0;
            end else begin
                exp_err = (err_q.size() > 0 && err_q[0] == cyc);
                if (exp_err) void'(err_q.pop_front());
                chk("err_pulse", {31'd0, bus.err}, {31'd0, exp_err});
                if (prev_stall) begin
                    chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
                    chk("stall_hold", bus.instr, prev_instr);
                end
                if (bus.instr_valid && bus.instr_ready) begin
                    if (exp_q.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL unexpected_word: got %h, expected no word", bus.instr);
                    end else begin
                        exp_w = exp_q.pop_front();
                        chk("word", bus.instr, exp_w);
                    end
                end
                prev_stall = bus.instr_valid && !bus.instr_ready;
                prev_instr = bus.instr;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rd = '0; bus.req_rs = '0;
        bus.req_rt = '0; bus.req_imm = '0; bus.instr_ready = 1'b1;
        #2;
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // add, then first-word latency
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF);
        chk("add_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("add_word", bus.instr, 32'h0022_1820);

        // back-to-back stream
        send(5'd11, 5'd17, 5'd0, 5'd8, 32'h0000_0005);
        send(5'd19, 5'd0, 5'd1, 5'd2, 32'h0000_FFFF);
        send(5'd10, 5'd7, 5'd31, 5'd9, 32'h1234_5678);
        chk("jr_word", bus.instr, 32'h03E0_0009);
        idle(3);

        // long li
        send(5'd21, 5'd9, 5'd7, 5'd4, 32'h1234_5678);
`ifdef LI_EXPAND_EN
        chk("li_w1", bus.instr, 32'h3404_1234);
        @(negedge clk); chk("li_rdy2", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk); #1 chk("li_w2", bus.instr, 32'h0004_2400);
        @(negedge clk); chk("li_rdy3", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk); #1 chk("li_w3", bus.instr, 32'h3484_5678);
        @(negedge clk); chk("li_rdy_end", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
`else
        chk("li_off_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("li_off_err", {31'd0, bus.err}, 32'd1);
`endif
        idle(2);

        // short li
        send(5'd21, 5'd1, 5'd2, 5'd4, 32'h0000_5678);
`ifdef LI_EXPAND_EN
        chk("li_short", bus.instr, 32'h3404_5678);
`else
        chk("li_short_off", {31'd0, bus.err}, 32'd1);
`endif
        idle(3);

        // backpressure on sll: held word, no acceptance while stalled
        bus.instr_ready = 1'b0;
        send(5'd7, 5'd4, 5'd13, 5'd4, 32'h0000_0010);
        bus.req_valid = 1'b1; bus.req_op = 5'd11; bus.req_rs = 5'd2; bus.req_rt = 5'd3;
        bus.req_imm = 32'h0000_0042;
        repeat (4) begin
            @(negedge clk);
            chk("bp_hold", bus.instr, 32'h0004_2400);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.instr_ready = 1'b1;
        send(5'd11, 5'd0, 5'd2, 5'd3, 32'h0000_0042);
        idle(3);

        // illegal op
        send(5'd25, 5'd1, 5'd2, 5'd3, 32'h0000_0001);
        chk("ill_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("ill_err", {31'd0, bus.err}, 32'd1);
        @(posedge clk); #1 chk("ill_err_once", {31'd0, bus.err}, 32'd0);
        idle(2);

        // reset in the middle of a li
        send(5'd21, 5'd0, 5'd0, 5'd4, 32'h1234_5678);
`ifdef LI_EXPAND_EN
        chk("rst_li_w1", bus.instr, 32'h3404_1234);
`endif
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_mid_instr", bus.instr, 32'd0);
        exp_q.delete();
        err_q.delete();
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        #1 chk("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
        idle(6);

        // randomized traffic with random backpressure
        repeat (800) begin
            @(posedge clk); #1;
            bus.instr_ready = ($urandom_range(0, 9) < 7);
            bus.req_valid   = ($urandom_range(0, 9) < 6);
            bus.req_op      = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(22, 31))
                                                          : 5'($urandom_range(0, 21));
            bus.req_rd  = 5'($urandom);
            bus.req_rs  = 5'($urandom);
            bus.req_rt  = 5'($urandom);
            bus.req_imm = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_FFFF) : $urandom;
            @(negedge clk);
            if (bus.req_valid && bus.req_ready)
                model(bus.req_op, bus.req_rd, bus.req_rs, bus.req_rt, bus.req_imm, cyc + 1);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.instr_ready = 1'b1;
        n = 0;
        while ((exp_q.size() > 0 || err_q.size() > 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        idle(2);
        chk("drain_words", exp_q.size(), 32'd0);
        chk("drain_errs", err_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming MIPS instruction encoder for the project's ISA subset. It accepts symbolic instruction requests (operation code, register fields, immediate) over a valid/ready handshake and emits 32-bit machine words over a second valid/ready handshake. Its output encoding is exactly what the control decoder accepts. It sits in front of instruction memory as the program loader and self-test program generator, and it expands the `li` pseudo-op into a multi-word sequence.

## Interface
- Parameters: none.
- `clk  input  1  system clock; all state updates on the rising edge`
- `reset  input  1  asynchronous, active-high reset`
- `req_valid  input  1  request present`
- `req_ready  output  1  encoder accepts the request this cycle`
- `req_op  input  5  operation: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sll, 8 srl, 9 sra, 10 jr, 11 addi, 12 andi, 13 ori, 14 xori, 15 lw, 16 sw, 17 j, 18 jal, 19 beq, 20 bne, 21 li; 22–31 illegal`
- `req_rd, req_rs, req_rt  input  5 each  register fields`
- `req_imm  input  32  immediate: shamt in [4:0], imm16 in [15:0], target in [25:0], or li value`
- `instr_valid  output  1  instr holds a valid word`
- `instr_ready  input  1  downstream accepts instr`
- `instr  output  32  encoded word`
- `err  output  1  one-cycle pulse: an illegal request was accepted and dropped`

## Operation
- Encodings:
  - R-type: {6'b0, rs, rt, rd, shamt, funct}.
    - Funct values: add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010, sll 000000, srl 000010, sra 000011, jr 001001.
    - Shifts force rs=0 and take shamt from req_imm[4:0]. All other R-type ops use shamt=0.
    - jr forces rt=rd=0.
  - I-type: {op, rs, rt, imm[15:0]}.
    - Opcodes: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101.
  - J-type: {op, imm[25:0]}, with j 000010 and jal 000011.
- Fields not used by an op are forced to 0, ignoring whatever the request carries.
- Output register: `instr`/`instr_valid` form a registered stage.
  - The stage loads when it is empty or when `instr_ready` is high, i.e. `load = !instr_valid || instr_ready`.
  - `instr` must hold stable while `instr_valid && !instr_ready`.
- State machine: IDLE, LI_SHIFT, LI_LOW.
  - IDLE: `req_ready = load`.
    - A handshake with a normal op loads one word.
    - A handshake with an illegal op loads nothing and pulses `err` in the next cycle.
  - `li` with req_imm[31:16] == 0:
    - Emit `ori rt,$0,imm[15:0]` only.
    - Stay in IDLE.
  - `li` with req_imm[31:16] != 0:
    - Emit `ori rt,$0,imm[31:16]`.
    - Latch rt and imm[15:0], then go to LI_SHIFT.
  - LI_SHIFT: `req_ready = 0`. On load, emit `sll rt,rt,16` and go to LI_LOW.
  - LI_LOW: `req_ready = 0`. On load, emit `ori rt,rt,imm[15:0]` and go to IDLE.
- Reset values: state IDLE, `instr_valid` 0, `instr` 0, `err` 0, latched rt and imm 0. `req_ready` is 1 after reset, since the output stage is empty.
- Reset asserted mid-sequence aborts the `li`. Remaining words are never emitted, and any held word is discarded.

## Timing
- Latency: a request accepted at edge N appears on `instr` with `instr_valid` high after edge N.
- Throughput: one word per cycle with no backpressure. A full `li` takes 3 consecutive cycles.
- `req_ready` depends combinationally on `instr_ready` and state. It must not depend on `req_valid`.
- `err` is high for exactly the one cycle after the illegal handshake, independent of `instr_ready`.
- An `instr` handshake and a new request handshake in the same cycle are allowed: the old word leaves and the new word loads at the same edge.

## Configuration
- `LI_EXPAND_EN`:
  - Defined: op 21 expands as described, using the LI_SHIFT and LI_LOW states.
  - Undefined: op 21 is treated as illegal (`err` pulse, no word emitted). The state machine reduces to IDLE, and `req_ready = load` at all times.

## Test plan
- add rd=3 rs=1 rt=2 with `instr_ready`=1 → `instr`=0x00221820, `instr_valid` high one cycle after the handshake.
- Stream addi rt=8 rs=0 imm=5, then beq rs=1 rt=2 imm=0xFFFF, then jr rs=31 → 0x20080005, 0x1022FFFF, 0x03E00009 on consecutive cycles.
- li rt=4 imm=0x12345678 → 0x34041234, 0x00042400, 0x34845678 on consecutive cycles, with `req_ready`=0 during the 2nd and 3rd cycles.
- li rt=4 imm=0x00005678 → single word 0x34045678. With `LI_EXPAND_EN` undefined, the same request produces no word and a one-cycle `err` pulse.
- Hold `instr_ready`=0 for 4 cycles after sll rd=4 rt=4 imm=16 → `instr` stays 0x00042400, `req_ready`=0, and the next request is accepted only once `instr_ready` returns to 1.
- req_op=25 → `err` pulses once, `instr_valid` stays 0. Assert `reset` after the first word of a li → `instr_valid`=0 immediately, and the 2nd and 3rd words are never emitted.
